// File: rtl/ps2_keycode_queue_pkg.sv
// Shared PS/2 receiver definitions: frame constants, receiver states, parity helper.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // PS/2 uses odd parity: the data bits plus the parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keycode_queue_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge strobe, frame FSM and inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic                     byte_valid,
  output logic [PS2_DATA_BITS-1:0] byte_data,
  output logic                     parity_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = $clog2(PS2_DATA_BITS);

  logic [1:0]               clk_sync;
  logic [1:0]               dat_sync;
  logic                     clk_prev;
  logic                     fe;
  logic                     dat_fe;
  rx_state_t                state;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic [BW-1:0]            bit_idx;
  logic                     par_bit;
  logic [TW-1:0]            tmo_cnt;
  logic                     frame_done;
  logic                     frame_ok;

  // dat_fe is delayed alongside fe so the sampled data matches the strobed clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
      fe       <= 1'b0;
      dat_fe   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
      fe       <= clk_prev & ~clk_sync[1];
      dat_fe   <= dat_sync[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state == IDLE || fe) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + TW'(1);

      if (fe) begin
        case (state)
          IDLE: begin
            if (!dat_fe) begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_fe, shreg[PS2_DATA_BITS-1:1]};
            bit_idx <= bit_idx + BW'(1);
            if (bit_idx == BW'(PS2_DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_fe;
            state   <= STOP;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
      end
    end
  end

  // Result is decoded on the stop-bit strobe itself so the push lands in that same cycle.
  assign frame_done = fe && (state == STOP);
  assign frame_ok   = odd_parity_ok(shreg, par_bit) && dat_fe;
  assign byte_valid = frame_done && frame_ok;
  assign parity_err = frame_done && !frame_ok;
  assign byte_data  = shreg;

endmodule

// File: rtl/ps2_keycode_queue.sv
// PS/2 keyboard front end: frame receiver feeding a show-ahead scan-code queue with overflow flag.
module ps2_keycode_queue
  import ps2_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  input  logic                         rd_en,
  input  logic                         ovf_clr,
  output logic [PS2_DATA_BITS-1:0]     keycode,
  output logic                         kb_ready,
  output logic                         kb_overflow,
  output logic                         parity_err,
  output logic [$clog2(QUEUE_DEPTH):0] count
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);

  logic                     byte_valid;
  logic [PS2_DATA_BITS-1:0] byte_data;
  logic [AW:0]              wr_ptr;
  logic [AW:0]              rd_ptr;
  logic [PS2_DATA_BITS-1:0] mem [QUEUE_DEPTH];
  logic                     empty;
  logic                     full;
  logic                     do_pop;
  logic                     do_push;
  logic                     drop;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .parity_err(parity_err)
  );

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = rd_en && !empty;
  // A pop frees the slot in the same cycle, so a full queue still accepts a push alongside it.
  assign do_push = byte_valid && (!full || do_pop);
  assign drop    = byte_valid && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= byte_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      kb_overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)         kb_overflow <= 1'b1;
      else if (ovf_clr) kb_overflow <= 1'b0;
    end
  end

  assign count    = wr_ptr - rd_ptr;
  assign kb_ready = !empty;
  assign keycode  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
